// File: rtl/pcw_mouse_accumulator.sv
// PS/2 mouse motion accumulator for the PCW mouse port: integrates packet deltas per axis,
// latches sticky buttons/overflow, and hands out read-and-clear snapshots to the CPU side.
module pcw_mouse_accumulator #(
  parameter int CW       = 8,
  parameter int SHIFT    = 0,
  parameter int SATURATE = 1,
  parameter int INVERT_Y = 1
) (
  input  logic          clk_sys_i,
  input  logic          reset_i,
  input  logic [24:0]   ps2_mouse_i,
  input  logic          rd_req_i,
  output logic          rd_valid_o,
  output logic [CW-1:0] rd_x_o,
  output logic [CW-1:0] rd_y_o,
  output logic [2:0]    rd_buttons_o,
  output logic [1:0]    rd_ovf_o,
  output logic          moved_o
);

  localparam int AW = CW + SHIFT;
  localparam int SW = (AW + 1 > 11) ? AW + 1 : 11;
  localparam logic [AW-1:0]        FRAC_MASK = AW'((1 << SHIFT) - 1);
  localparam logic signed [SW-1:0] MAXV      = SW'((1 << (AW - 1)) - 1);
  localparam logic signed [SW-1:0] MINV      = ~MAXV;

  logic          tog_q, armed_q;
  logic [AW-1:0] acc_x_q, acc_y_q, acc_x_d, acc_y_d;
  logic [2:0]    btn_q, btn_d;
  logic [1:0]    ovf_q, ovf_d;
  logic          rd_valid_q;
  logic [CW-1:0] rd_x_q, rd_y_q;
  logic [2:0]    rd_btn_q;
  logic [1:0]    rd_ovf_q;

  logic          pkt;
  logic [9:0]    dx, dy_raw, dy;
  logic [AW-1:0] base_x, base_y;
  logic          ov_x, ov_y;
  logic          unused_bit3;

  assign unused_bit3 = ps2_mouse_i[3];

  // Overflowed PS/2 deltas are replaced by the extreme value in the reported direction.
  function automatic logic [9:0] decode(input logic ovf, input logic sign, input logic [7:0] mag);
    if (ovf) decode = sign ? 10'h300 : 10'h0FF;
    else     decode = {sign, 1'b0, mag} | {2'b00, mag} & 10'h0FF | {sign, sign, 8'h00};
  endfunction

  function automatic logic [AW:0] accum(input logic [AW-1:0] base, input logic [9:0] d,
                                        input logic en);
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] de;
    de = en ? $signed({{(SW-10){d[9]}}, d}) : '0;
    s  = $signed({{(SW-AW){base[AW-1]}}, base}) + de;
    if (s > MAXV)      accum = {1'b1, (SATURATE != 0) ? MAXV[AW-1:0] : s[AW-1:0]};
    else if (s < MINV) accum = {1'b1, (SATURATE != 0) ? MINV[AW-1:0] : s[AW-1:0]};
    else               accum = {1'b0, s[AW-1:0]};
  endfunction

  always_comb begin
    pkt    = armed_q && (tog_q != ps2_mouse_i[24]);
    dx     = decode(ps2_mouse_i[6], ps2_mouse_i[4], ps2_mouse_i[15:8]);
    dy_raw = decode(ps2_mouse_i[7], ps2_mouse_i[5], ps2_mouse_i[23:16]);
    dy     = (INVERT_Y != 0) ? (10'd0 - dy_raw) : dy_raw;
    // A read drops the reported integer part but keeps the sub-count fraction.
    base_x = rd_req_i ? (acc_x_q & FRAC_MASK) : acc_x_q;
    base_y = rd_req_i ? (acc_y_q & FRAC_MASK) : acc_y_q;
    {ov_x, acc_x_d} = accum(base_x, dx, pkt);
    {ov_y, acc_y_d} = accum(base_y, dy, pkt);
    btn_d  = (rd_req_i ? ps2_mouse_i[2:0] : btn_q) | (pkt ? ps2_mouse_i[2:0] : 3'b000);
    ovf_d  = (rd_req_i ? 2'b00 : ovf_q) | {ov_y, ov_x};
  end

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      tog_q      <= 1'b0;
      armed_q    <= 1'b0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      btn_q      <= '0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_btn_q   <= '0;
      rd_ovf_q   <= '0;
    end else begin
      tog_q      <= ps2_mouse_i[24];
      armed_q    <= 1'b1;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      btn_q      <= btn_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_req_i;
      if (rd_req_i) begin
        rd_x_q   <= acc_x_q[AW-1:SHIFT];
        rd_y_q   <= acc_y_q[AW-1:SHIFT];
        rd_btn_q <= btn_q;
        rd_ovf_q <= ovf_q;
      end
    end
  end

  assign rd_valid_o   = rd_valid_q;
  assign rd_x_o       = rd_x_q;
  assign rd_y_o       = rd_y_q;
  assign rd_buttons_o = rd_btn_q;
  assign rd_ovf_o     = rd_ovf_q;
  assign moved_o      = (|acc_x_q[AW-1:SHIFT]) | (|acc_y_q[AW-1:SHIFT]) | (|btn_q);

endmodule
